matrix_row_scanner: RTL and testbench
=====================================

// Module: matrix_row_scanner
// PURPOSE
//  Time-multiplexed driver for one dot-matrix glyph; generalises the per-row combinational presets.
//  Holds a glyph code, steps a one-hot row strobe across ROWS rows with a programmable dwell,
//  and drives that row's COLS column pattern from a glyph ROM.
//  Sits between the digit/select logic (code source) and the matrix pins; one instance per glyph.
// PARAMETERS
//  ROWS      7   rows scanned per frame (>=2)
//  COLS      5   column bits per row
//  CODE_W    2   glyph code width; ROM holds 2**CODE_W glyphs
//  DWELL     4   clk cycles each row stays lit (>=1)
//  COL_INV   0   1 = column outputs active-low (bitwise inverted after blanking)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  en         in   1       scan enable; 0 freezes dwell/row counters and outputs
//  blank      in   1       1 = force all columns off (rows keep scanning)
//  code_in    in   CODE_W  requested glyph code
//  code_load  in   1       1-cycle strobe: capture code_in into pending register
//  row_n      out  ROWS    one-hot active-low row strobe
//  cols       out  COLS    column pattern for active row
//  frame_start out 1       1-cycle pulse when row 0 becomes active
//  pending    out  1       1 = a loaded code awaits the next frame boundary
// BEHAVIOUR
//  Reset: row_n all 1s, cols = 0 (all ones if COL_INV), frame_start 0, pending 0,
//   active code 0, pending code 0, row index 0, dwell count 0. Reset wins over all inputs.
//  All outputs are registered. First en=1 cycle after reset: row_n[0]=0, cols=ROM[code 0][row 0], frame_start=1.
//  Dwell: counter 0..DWELL-1 advances each en=1 cycle; at DWELL-1 it wraps and row index advances.
//  Row index wraps ROWS-1 -> 0; that transition pulses frame_start and is the frame boundary.
//  Code handoff: code_load captures code_in, sets pending. At frame boundary, if pending:
//   active code <= pending code, pending <= 0; row 0 of the new frame already uses the new code.
//   Load on the same cycle as a boundary: it goes into pending, applies at the following boundary.
//   Repeated loads before a boundary: last one wins. code_load is honoured even when en=0.
//  en=0: counters, row_n, cols, active code hold; frame_start forced 0.
//  blank=1: cols = off pattern next cycle; row/dwell keep running; no effect on code handoff.
//  Column bit COLS-1 is leftmost. Row 0 is top. ROM lookup is combinational; one register stage.
//  Mid-frame reset: scan restarts at row 0 with code 0; any pending code is discarded.
// STRUCTURE
//  Package matrix_pkg: glyph ROM as function glyph_row(code,row) returning COLS bits, default
//   ROWS/COLS constants. Unlisted codes/rows return all zeros.
//  Sub-module scan_timer: dwell + row counters, emits row index and boundary strobe.
//  Required ROM row 4 contents (COLS=5): code0=11000, code1=10111, code2=11100, code3=11111.
// TESTING
//  Reset then en=1: row_n steps 1111110 -> 1111101 ... every 4 cycles; frame_start every 28 cycles.
//  code_load code_in=1 at row 2: rows 2..6 keep code 0; next frame row 4 cols=10111, pending clears.
//  code_load=3 on the boundary cycle, then code_load=2 mid-frame: frame n+1 uses 3, frame n+2 uses 2.
//  blank=1 for 10 cycles: cols=00000 while row_n keeps advancing; COL_INV=1 instance gives 11111.
//  en=0 for 20 cycles mid-row: row_n/cols frozen, frame_start 0; resume completes remaining dwell.
//  reset asserted at row 5 with pending set: next cycle row_n all 1s, pending 0; restart uses code 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg
//   Shared constants and the glyph ROM for the dot-matrix row scanner.
//   glyph_row(code, row) returns the MATRIX_COLS-bit column pattern for one
//   row of one glyph; bit MATRIX_COLS-1 is the leftmost column, row 0 is the
//   top row. Codes or rows not listed in the table return all zeros.
package matrix_pkg;

    localparam int MATRIX_ROWS = 7;
    localparam int MATRIX_COLS = 5;

    function automatic logic [MATRIX_COLS-1:0] glyph_row(
        input logic [7:0] code,
        input logic [7:0] row
    );
        logic [MATRIX_COLS-1:0] pat;
        pat = '0;
        case (code)
            8'd0: case (row)
                8'd0: pat = 5'b01110;
                8'd1: pat = 5'b10001;
                8'd2: pat = 5'b10011;
                8'd3: pat = 5'b10101;
                8'd4: pat = 5'b11000;
                8'd5: pat = 5'b10001;
                8'd6: pat = 5'b01110;
                default: pat = '0;
            endcase
            8'd1: case (row)
                8'd0: pat = 5'b00100;
                8'd1: pat = 5'b01100;
                8'd2: pat = 5'b00100;
                8'd3: pat = 5'b00100;
                8'd4: pat = 5'b10111;
                8'd5: pat = 5'b00100;
                8'd6: pat = 5'b01110;
                default: pat = '0;
            endcase
            8'd2: case (row)
                8'd0: pat = 5'b01110;
                8'd1: pat = 5'b10001;
                8'd2: pat = 5'b00001;
                8'd3: pat = 5'b00010;
                8'd4: pat = 5'b11100;
                8'd5: pat = 5'b01000;
                8'd6: pat = 5'b11111;
                default: pat = '0;
            endcase
            8'd3: case (row)
                8'd0: pat = 5'b11111;
                8'd1: pat = 5'b00010;
                8'd2: pat = 5'b00100;
                8'd3: pat = 5'b00010;
                8'd4: pat = 5'b11111;
                8'd5: pat = 5'b10001;
                8'd6: pat = 5'b01110;
                default: pat = '0;
            endcase
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/matrix_row_scanner_scan_timer.sv
// scan_timer
//   Dwell and row counters for the matrix scanner. Each enabled cycle the
//   dwell counter advances 0..DWELL-1; on its wrap the row index advances
//   0..ROWS-1 and wraps.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     en           advance counters this cycle
//     row_idx      current row index
//     frame_first  counters sit at row 0, dwell 0 (first cycle of a frame)
//     boundary     this enabled cycle wraps row ROWS-1 back to row 0
module scan_timer #(
    parameter int ROWS  = 7,
    parameter int DWELL = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     frame_first,
    output logic                     boundary
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          dwell_last;
    logic          row_last;

    assign dwell_last  = (dwell_q == DW'(DWELL - 1));
    assign row_last    = (row_q == RW'(ROWS - 1));
    assign boundary    = en && dwell_last && row_last;
    assign frame_first = (row_q == '0) && (dwell_q == '0);
    assign row_idx     = row_q;

    always_comb begin
        row_d   = row_q;
        dwell_d = dwell_q;
        if (en) begin
            if (dwell_last) begin
                dwell_d = '0;
                row_d   = row_last ? '0 : row_q + RW'(1);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q   <= '0;
            dwell_q <= '0;
        end else begin
            row_q   <= row_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner
//   Time-multiplexed driver for one dot-matrix glyph. Steps an active-low
//   one-hot row strobe across ROWS rows, DWELL cycles per row, and drives the
//   active row's column pattern from the glyph ROM. New glyph codes wait in a
//   pending register and take effect at the next frame boundary so a frame is
//   never drawn with two glyphs.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     en           scan enable; 0 freezes counters and outputs
//     blank        force columns to the off pattern (rows keep scanning)
//     code_in      requested glyph code
//     code_load    strobe capturing code_in into the pending register
//     row_n        one-hot active-low row strobe (registered)
//     cols         column pattern of the active row (registered)
//     frame_start  one-cycle pulse when row 0 becomes active (registered)
//     pending      a loaded code awaits the next frame boundary
module matrix_row_scanner
    import matrix_pkg::*;
#(
    parameter int ROWS    = MATRIX_ROWS,
    parameter int COLS    = MATRIX_COLS,
    parameter int CODE_W  = 2,
    parameter int DWELL   = 4,
    parameter int COL_INV = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              blank,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_load,
    output logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   cols,
    output logic              frame_start,
    output logic              pending
);

    localparam int RW = $clog2(ROWS);
    localparam logic [COLS-1:0] COLS_OFF = (COL_INV != 0) ? '1 : '0;

    logic [RW-1:0]     row_idx;
    logic              frame_first;
    logic              boundary;

    logic [CODE_W-1:0] code_act_q,  code_act_d;
    logic [CODE_W-1:0] code_pend_q, code_pend_d;
    logic              pending_q,   pending_d;
    logic [ROWS-1:0]   row_n_q,     row_n_d;
    logic [COLS-1:0]   cols_q,      cols_d;
    logic              frame_start_q, frame_start_d;
    logic [COLS-1:0]   rom_pat;
    logic [COLS-1:0]   lit_pat;

    scan_timer #(
        .ROWS  (ROWS),
        .DWELL (DWELL)
    ) u_scan_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .row_idx     (row_idx),
        .frame_first (frame_first),
        .boundary    (boundary)
    );

    always_comb begin
        rom_pat = COLS'(glyph_row(8'(code_act_q), 8'(row_idx)));
        lit_pat = blank ? '0 : rom_pat;
        if (COL_INV != 0) begin
            lit_pat = ~lit_pat;
        end
    end

    // Handoff swaps first, then a load is captured: a load landing on the
    // boundary cycle therefore stays pending until the following boundary.
    always_comb begin
        code_act_d  = code_act_q;
        code_pend_d = code_pend_q;
        pending_d   = pending_q;
        if (boundary && pending_q) begin
            code_act_d = code_pend_q;
            pending_d  = 1'b0;
        end
        if (code_load) begin
            code_pend_d = code_in;
            pending_d   = 1'b1;
        end
    end

    always_comb begin
        row_n_d       = row_n_q;
        cols_d        = cols_q;
        frame_start_d = 1'b0;
        if (en) begin
            row_n_d       = ~(ROWS'(1) << row_idx);
            cols_d        = lit_pat;
            frame_start_d = frame_first;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_act_q    <= '0;
            code_pend_q   <= '0;
            pending_q     <= 1'b0;
            row_n_q       <= '1;
            cols_q        <= COLS_OFF;
            frame_start_q <= 1'b0;
        end else begin
            code_act_q    <= code_act_d;
            code_pend_q   <= code_pend_d;
            pending_q     <= pending_d;
            row_n_q       <= row_n_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_n       = row_n_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_matrix_row_scanner.sv
module tb_matrix_row_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       blank = 1'b0;
    logic [1:0] code_in = 2'd0;
    logic       code_load = 1'b0;

    logic [6:0] row_n, row_n_i;
    logic [4:0] cols, cols_i;
    logic       frame_start, frame_start_i;
    logic       pending, pending_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matrix_row_scanner #(.ROWS(7), .COLS(5), .CODE_W(2), .DWELL(4), .COL_INV(0)) dut (
        .clk(clk), .reset(reset), .en(en), .blank(blank), .code_in(code_in),
        .code_load(code_load), .row_n(row_n), .cols(cols),
        .frame_start(frame_start), .pending(pending)
    );

    matrix_row_scanner #(.ROWS(7), .COLS(5), .CODE_W(2), .DWELL(4), .COL_INV(1)) dut_i (
        .clk(clk), .reset(reset), .en(en), .blank(blank), .code_in(code_in),
        .code_load(code_load), .row_n(row_n_i), .cols(cols_i),
        .frame_start(frame_start_i), .pending(pending_i)
    );

    // Reference glyph table, written out independently of the RTL package.
    logic [4:0] rom [0:3][0:6] = '{
        '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11000, 5'b10001, 5'b01110},
        '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b10111, 5'b00100, 5'b01110},
        '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b11100, 5'b01000, 5'b11111},
        '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b11111, 5'b10001, 5'b01110}
    };

    // Behavioural model: updated at each rising edge from the inputs applied
    // for that edge; the expected post-edge outputs go into the scoreboard.
    int         m_row = 0;
    int         m_dw = 0;
    int         m_act = 0;
    int         m_pcode = 0;
    bit         m_pend = 1'b0;
    logic [6:0] m_row_n = 7'h7f;
    logic [4:0] m_cols = 5'b0;
    bit         m_fs = 1'b0;
    bit         m_bnd;
    logic [27:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_row = 0; m_dw = 0; m_act = 0; m_pcode = 0; m_pend = 1'b0;
            m_row_n = 7'h7f; m_cols = 5'b0; m_fs = 1'b0;
        end else begin
            m_bnd = en && (m_row == 6) && (m_dw == 3);
            if (en) begin
                m_row_n = ~(7'b1 << m_row);
                m_cols  = blank ? 5'b0 : rom[m_act][m_row];
                m_fs    = (m_row == 0) && (m_dw == 0);
                if (m_dw == 3) begin
                    m_dw  = 0;
                    m_row = (m_row == 6) ? 0 : m_row + 1;
                end else begin
                    m_dw = m_dw + 1;
                end
            end else begin
                m_fs = 1'b0;
            end
            if (m_bnd && m_pend) begin
                m_act  = m_pcode;
                m_pend = 1'b0;
            end
            if (code_load) begin
                m_pcode = int'(code_in);
                m_pend  = 1'b1;
            end
        end
        exp_q.push_back({m_row_n, m_cols, m_fs, m_pend, m_row_n, ~m_cols, m_fs, m_pend});
    end

    logic [27:0] sb_exp;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            checks++;
            if ({row_n, cols, frame_start, pending, row_n_i, cols_i, frame_start_i, pending_i} !== sb_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual=%h required=%h", $time,
                         {row_n, cols, frame_start, pending, row_n_i, cols_i, frame_start_i, pending_i}, sb_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; code_load = 1'b1; code_in = 2'd3; blank = 1'b0;
        repeat (3) tick();
        checks++;
        if ({row_n, cols, frame_start, pending} !== {7'h7f, 5'b00000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state actual=%b required=%b", {row_n, cols, frame_start, pending}, {7'h7f, 5'b00000, 2'b00});
        end
        checks++;
        if (cols_i !== 5'b11111) begin
            errors++;
            $display("FAIL reset_cols_inv actual=%b required=11111", cols_i);
        end
        reset = 1'b0; en = 1'b0; code_load = 1'b0; code_in = 2'd0;
        tick();
        checks++;
        if ({row_n, frame_start, pending} !== {7'h7f, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_after_reset actual=%b required=%b", {row_n, frame_start, pending}, {7'h7f, 2'b00});
        end
    endtask

    task automatic test_scan();
        int fs_cnt;
        fs_cnt = 0;
        en = 1'b1;
        tick();
        checks++;
        if ({row_n, cols, frame_start} !== {7'b1111110, 5'b01110, 1'b1}) begin
            errors++;
            $display("FAIL first_row actual=%b required=%b", {row_n, cols, frame_start}, {7'b1111110, 5'b01110, 1'b1});
        end
        for (int i = 1; i < 56; i++) begin
            tick();
            if (frame_start) fs_cnt++;
            if (i == 4) begin
                checks++;
                if (row_n !== 7'b1111101) begin
                    errors++;
                    $display("FAIL row_step actual=%b required=1111101", row_n);
                end
            end
        end
        checks++;
        if (fs_cnt !== 1) begin
            errors++;
            $display("FAIL frame_period actual=%0d required=1", fs_cnt);
        end
    endtask

    task automatic test_code_load();
        int stage;
        int n;
        n = 0;
        while (!(m_row == 2 && m_dw == 0) && n < 40) begin tick(); n++; end
        code_in = 2'd1; code_load = 1'b1;
        tick();
        code_load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL load_pending actual=%b required=1", pending);
        end
        stage = 0;
        for (int i = 0; i < 80 && stage < 3; i++) begin
            tick();
            case (stage)
                0: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b11000) begin
                        errors++;
                        $display("FAIL load_old_frame actual=%b required=11000", cols);
                    end
                    stage = 1;
                end
                1: if (frame_start) begin
                    checks++;
                    if (pending !== 1'b0) begin
                        errors++;
                        $display("FAIL load_pending_clear actual=%b required=0", pending);
                    end
                    stage = 2;
                end
                default: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b10111) begin
                        errors++;
                        $display("FAIL load_new_frame actual=%b required=10111", cols);
                    end
                    stage = 3;
                end
            endcase
        end
        if (stage != 3) begin
            errors++; checks++;
            $display("FAIL timeout_code_load actual=stage%0d required=stage3", stage);
        end
    endtask

    task automatic test_back_to_back();
        int stage;
        int n;
        n = 0;
        while (!(m_row == 6 && m_dw == 3) && n < 40) begin tick(); n++; end
        code_in = 2'd3; code_load = 1'b1;
        tick();
        code_load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending_after_boundary_load actual=%b required=1", pending);
        end
        stage = 0;
        for (int i = 0; i < 120 && stage < 5; i++) begin
            tick();
            case (stage)
                0: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b10111) begin
                        errors++;
                        $display("FAIL b2b_frame_n actual=%b required=10111", cols);
                    end
                    stage = 1;
                end
                1: if (frame_start) stage = 2;
                2: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b11111) begin
                        errors++;
                        $display("FAIL b2b_frame_n1 actual=%b required=11111", cols);
                    end
                    code_in = 2'd2; code_load = 1'b1;
                    tick();
                    code_load = 1'b0;
                    stage = 3;
                end
                3: if (frame_start) stage = 4;
                default: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b11100) begin
                        errors++;
                        $display("FAIL b2b_frame_n2 actual=%b required=11100", cols);
                    end
                    stage = 5;
                end
            endcase
        end
        if (stage != 5) begin
            errors++; checks++;
            $display("FAIL timeout_back_to_back actual=stage%0d required=stage5", stage);
        end
    endtask

    task automatic test_blank();
        logic [6:0] prev;
        int changes;
        changes = 0;
        blank = 1'b1;
        tick();
        prev = row_n;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cols !== 5'b00000 || cols_i !== 5'b11111) begin
                errors++;
                $display("FAIL blank_cols actual=%b/%b required=00000/11111", cols, cols_i);
            end
            tick();
            if (row_n !== prev) changes++;
            prev = row_n;
        end
        blank = 1'b0;
        checks++;
        if (changes < 2) begin
            errors++;
            $display("FAIL blank_rows_advance actual=%0d required>=2", changes);
        end
    endtask

    task automatic test_freeze();
        logic [6:0] r;
        logic [4:0] c;
        int n;
        n = 0;
        while (m_dw != 2 && n < 10) begin tick(); n++; end
        en = 1'b0;
        tick();
        r = row_n; c = cols;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({row_n, cols, frame_start} !== {r, c, 1'b0}) begin
                errors++;
                $display("FAIL freeze_hold actual=%b required=%b", {row_n, cols, frame_start}, {r, c, 1'b0});
            end
        end
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (row_n !== r) break;
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL freeze_resume_dwell actual=%0d required=2", n);
        end
    endtask

    task automatic test_mid_reset();
        int stage;
        int n;
        n = 0;
        while (m_row != 5 && n < 40) begin tick(); n++; end
        code_in = 2'd2; code_load = 1'b1;
        tick();
        code_load = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if ({row_n, pending, frame_start, cols} !== {7'h7f, 1'b0, 1'b0, 5'b00000}) begin
            errors++;
            $display("FAIL midreset_state actual=%b required=%b", {row_n, pending, frame_start, cols}, {7'h7f, 7'b0});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({row_n, frame_start} !== {7'b1111110, 1'b1}) begin
            errors++;
            $display("FAIL midreset_restart actual=%b required=%b", {row_n, frame_start}, {7'b1111110, 1'b1});
        end
        stage = 0;
        for (int i = 0; i < 80 && stage < 3; i++) begin
            tick();
            case (stage)
                0: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b11000) begin
                        errors++;
                        $display("FAIL midreset_code0 actual=%b required=11000", cols);
                    end
                    stage = 1;
                end
                1: if (frame_start) stage = 2;
                default: if (row_n == 7'b1101111) begin
                    checks++;
                    if (cols !== 5'b11000) begin
                        errors++;
                        $display("FAIL midreset_discard actual=%b required=11000", cols);
                    end
                    stage = 3;
                end
            endcase
        end
        if (stage != 3) begin
            errors++; checks++;
            $display("FAIL timeout_mid_reset actual=stage%0d required=stage3", stage);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_code_load();
        test_back_to_back();
        test_blank();
        test_freeze();
        test_mid_reset();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
